// File: rtl/dff_bank_arbiter.sv
// Round-robin write arbiter for a shared DFF register bank with q/qb outputs.
// Optional DFF_ARB_WRCOUNT_EN adds write and abort counters.
module dff_bank_arbiter #(
  parameter int NREQ = 4,
  parameter int WIDTH = 8,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      q,
  output logic [WIDTH-1:0]      qb,
  output logic                  busy,
  output logic [IDW-1:0]        owner
`ifdef DFF_ARB_WRCOUNT_EN
  ,
  output logic [15:0]           wr_count,
  output logic [7:0]            abort_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    WRITE,
    ACK
  } state_t;

  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  state_t          state;
  logic [IDW-1:0]  win;
  logic [IDW-1:0]  k;
  logic            found;
  logic [NREQ-1:0] win_oh;
  logic [NREQ-1:0] own_oh;

  // First requester after the last owner, wrapping modulo NREQ.
  always_comb begin
    win   = owner;
    found = 1'b0;
    k     = '0;
    for (int i = 1; i <= NREQ; i++) begin
      k = IDW'((int'(owner) + i) % NREQ);
      if (!found && req[k]) begin
        found = 1'b1;
        win   = k;
      end
    end
  end

  assign win_oh = ONE << win;
  assign own_oh = ONE << owner;
  assign qb     = ~q;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      gnt   <= '0;
      ack   <= '0;
      q     <= '0;
      owner <= IDW'(NREQ - 1);
`ifdef DFF_ARB_WRCOUNT_EN
      wr_count    <= '0;
      abort_count <= '0;
`endif
    end else begin
      ack <= '0;
      unique case (state)
        IDLE: begin
          if (found) begin
            state <= GRANT;
            gnt   <= win_oh;
            owner <= win;
          end
        end
        GRANT: begin
          if (req[owner]) begin
            state <= WRITE;
          end else begin
            // Abort keeps owner so the pointer still moves past it.
            state <= IDLE;
            gnt   <= '0;
`ifdef DFF_ARB_WRCOUNT_EN
            if (abort_count != 8'hFF)
              abort_count <= abort_count + 8'd1;
`endif
          end
        end
        WRITE: begin
          q     <= wdata[int'(owner)*WIDTH +: WIDTH];
          state <= ACK;
          gnt   <= '0;
          ack   <= own_oh;
        end
        ACK: begin
          state <= IDLE;
`ifdef DFF_ARB_WRCOUNT_EN
          wr_count <= wr_count + 16'd1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Randomized bench for dff_bank_arbiter against a transaction-level model.
// Counter checks are active when DFF_ARB_WRCOUNT_EN is defined.
module tb_dff_bank_arbiter;

  localparam int NREQ = 4;
  localparam int WIDTH = 8;
  localparam int IDW = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      q;
  logic [WIDTH-1:0]      qb;
  logic                  busy;
  logic [IDW-1:0]        owner;
`ifdef DFF_ARB_WRCOUNT_EN
  logic [15:0]           wr_count;
  logic [7:0]            abort_count;
`endif

  int npass = 0;
  int ntot = 0;

  int               m_owner;
  logic [WIDTH-1:0] m_q;
  int               m_wr;
  int               m_ab;

  always #5 clk = ~clk;

  dff_bank_arbiter #(
    .NREQ(NREQ),
    .WIDTH(WIDTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .wdata(wdata),
    .gnt(gnt),
    .ack(ack),
    .q(q),
    .qb(qb),
    .busy(busy),
    .owner(owner)
`ifdef DFF_ARB_WRCOUNT_EN
    ,
    .wr_count(wr_count),
    .abort_count(abort_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic int rr(input logic [NREQ-1:0] m, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (m[(last + k) % NREQ]) return (last + k) % NREQ;
    return last;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt;
`ifdef DFF_ARB_WRCOUNT_EN
    chk("wr_count", wr_count, m_wr % 65536);
    chk("abort_count", abort_count, m_ab);
`endif
  endtask

  // Invariants sampled away from the active edge.
  always @(negedge clk) begin
    logic [WIDTH-1:0] nq;
    nq = ~q;
    if (reset === 1'b0) begin
      chk("gnt_onehot", ($countones(gnt) <= 1), 1);
      chk("ack_onehot", ($countones(ack) <= 1), 1);
      chk("qb_inv", qb, nq);
    end
  end

  task automatic txn(input logic [NREQ-1:0] m, input logic [WIDTH-1:0] d,
                     input bit abort);
    int w;
    logic [WIDTH-1:0] nq;
    req = m;
    for (int i = 0; i < NREQ; i++)
      wdata[i*WIDTH +: WIDTH] = WIDTH'($urandom);
    w = rr(m, m_owner);
    step;
    chk("gnt", gnt, 1 << w);
    chk("owner", owner, w);
    chk("busy_g", busy, 1);
    chk("ack_g", ack, 0);
    m_owner = w;
    if (abort) begin
      req[w] = 1'b0;
      step;
      m_ab = (m_ab < 255) ? m_ab + 1 : 255;
      chk("gnt_ab", gnt, 0);
      chk("busy_ab", busy, 0);
      chk("ack_ab", ack, 0);
      chk("q_ab", q, m_q);
      chk_cnt();
      return;
    end
    req = NREQ'($urandom) | NREQ'(1 << w);
    wdata[w*WIDTH +: WIDTH] = WIDTH'($urandom);
    step;
    chk("gnt_w", gnt, 1 << w);
    chk("q_hold", q, m_q);
    wdata[w*WIDTH +: WIDTH] = d;
    m_q = d;
    step;
    nq = ~m_q;
    chk("q", q, m_q);
    chk("qb", qb, nq);
    chk("ack", ack, 1 << w);
    chk("gnt_a", gnt, 0);
    chk("busy_a", busy, 1);
    req = '0;
    step;
    m_wr++;
    chk("ack_done", ack, 0);
    chk("busy_i", busy, 0);
    chk_cnt();
  endtask

  task automatic rst_mid(input logic [NREQ-1:0] m);
    int w;
    logic [WIDTH-1:0] ones;
    ones = '1;
    w = rr(m, m_owner);
    req = m;
    step;
    chk("gnt_r", gnt, 1 << w);
    step;
    wdata[w*WIDTH +: WIDTH] = ones;
    reset = 1'b1;
    step;
    m_owner = NREQ - 1;
    m_q = '0;
    m_wr = 0;
    m_ab = 0;
    chk("q_r", q, 0);
    chk("qb_r", qb, ones);
    chk("gnt_r0", gnt, 0);
    chk("ack_r", ack, 0);
    chk("busy_r", busy, 0);
    chk("owner_r", owner, NREQ - 1);
    chk_cnt();
    reset = 1'b0;
    req = '0;
    step;
    chk("ack_r1", ack, 0);
  endtask

  initial begin
    logic [WIDTH-1:0] ones;
    ones = '1;
    reset = 1'b1;
    req = '0;
    wdata = '0;
    m_owner = NREQ - 1;
    m_q = '0;
    m_wr = 0;
    m_ab = 0;
    step;
    step;
    chk("rst_gnt", gnt, 0);
    chk("rst_ack", ack, 0);
    chk("rst_q", q, 0);
    chk("rst_qb", qb, ones);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, NREQ - 1);
    chk_cnt();
    reset = 1'b0;

    txn(4'b0001, 8'hA5, 0);
    txn(4'b1111, 8'h11, 0);
    txn(4'b1111, 8'h22, 0);
    txn(4'b1111, 8'h33, 0);
    txn(4'b1111, 8'h44, 0);
    txn(4'b0101, 8'h55, 0);
    txn(4'b0101, 8'h66, 0);
    txn(4'b0010, 8'h77, 1);
    txn(4'b0011, 8'h88, 0);
    rst_mid(4'b0001);
    txn(4'b1111, 8'h99, 0);

    for (int n = 0; n < 200; n++) begin
      logic [NREQ-1:0] m;
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      if ($urandom_range(0, 24) == 0) rst_mid(m);
      else txn(m, WIDTH'($urandom), ($urandom_range(0, 5) == 0));
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
